// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target front end.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_FETCH,
    DATA,
    DONE
  } spi_state_e;

  localparam int RW_BIT         = 7;
  localparam int FRAME_BITS     = 16;
  localparam int BYTE_BITS      = 8;
  localparam int DEFAULT_ADDR_W = 6;
  localparam int DEFAULT_DATA_W = 8;
  localparam int CNT_W          = 5;

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer for an asynchronous pin, plus rise/fall pulses from one extra flop.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: 16-bit frames {rw,rsvd,addr} + data become single-cycle register accesses.
// Optional SPI_TARGET_STATUS_EN adds a saturating frame error counter (frame_err_cnt).
//
// state    | meaning
// IDLE     | waiting for cs_n fall
// CMD      | shifting in the command byte
// RD_FETCH | one wait cycle, then capture rd_data into tx_sr
// DATA     | shifting the data byte in (write) or out on miso (read)
// DONE     | frame complete, extra SCK edges ignored until cs_n rise
module spi_target
  import spi_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] address,
  output logic              write_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              read_en,
  input  logic [DATA_W-1:0] rd_data
`ifdef SPI_TARGET_STATUS_EN
  ,
  output logic [7:0]        frame_err_cnt
`endif
);

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
  logic sck_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clock(clock), .reset_n(reset_n), .d_i(sck),
    .q_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall));

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clock(clock), .reset_n(reset_n), .d_i(cs_n),
    .q_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall));

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset_n(reset_n), .d_i(mosi),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

  spi_state_e        state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_sr_q, tx_sr_q, wr_data_q, shift_in;
  logic [ADDR_W-1:0] address_q;
  logic              rw_q, fetch_wait_q, write_en_q, read_en_q, miso_q;
`ifdef SPI_TARGET_STATUS_EN
  logic [7:0]        err_cnt_q;
`endif

  assign shift_in = {rx_sr_q[DATA_W-2:0], mosi_s};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_sr_q      <= '0;
      tx_sr_q      <= '0;
      wr_data_q    <= '0;
      address_q    <= '0;
      rw_q         <= 1'b0;
      fetch_wait_q <= 1'b0;
      write_en_q   <= 1'b0;
      read_en_q    <= 1'b0;
      miso_q       <= 1'b0;
`ifdef SPI_TARGET_STATUS_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      write_en_q <= 1'b0;
      read_en_q  <= 1'b0;
      // cs_n rise outranks any SCK edge seen in the same cycle
      if (cs_rise && state_q != IDLE) begin
`ifdef SPI_TARGET_STATUS_EN
        if ((state_q != DONE || bit_cnt_q > CNT_W'(FRAME_BITS)) && err_cnt_q != 8'hFF)
          err_cnt_q <= err_cnt_q + 8'd1;
`endif
        state_q <= IDLE;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (cs_fall) begin
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= '0;
            fetch_wait_q <= 1'b0;
            state_q      <= CMD;
          end
          CMD: if (sck_rise) begin
            rx_sr_q   <= shift_in;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(BYTE_BITS - 1)) begin
              address_q <= shift_in[ADDR_W-1:0];
              rw_q      <= shift_in[RW_BIT];
              if (shift_in[RW_BIT]) begin
                read_en_q    <= 1'b1;
                fetch_wait_q <= 1'b1;
                state_q      <= RD_FETCH;
              end else begin
                state_q <= DATA;
              end
            end
          end else if (sck_fall) begin
            miso_q <= tx_sr_q[DATA_W-1];
          end
          RD_FETCH: if (fetch_wait_q) begin
            fetch_wait_q <= 1'b0;
          end else begin
            tx_sr_q <= rd_data;
            miso_q  <= rd_data[DATA_W-1];
            state_q <= DATA;
          end
          DATA: if (sck_rise) begin
            rx_sr_q   <= shift_in;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
              if (!rw_q) begin
                wr_data_q  <= shift_in;
                write_en_q <= 1'b1;
`ifdef SPI_TARGET_STATUS_EN
                if (address_q == '0) err_cnt_q <= '0;
`endif
              end
              state_q <= DONE;
            end
          // the fall closing byte 0 keeps bit 7 on miso; shifting starts after byte 1's first rise
          end else if (sck_fall && bit_cnt_q > CNT_W'(BYTE_BITS)) begin
            tx_sr_q <= tx_sr_q << 1;
            miso_q  <= tx_sr_q[DATA_W-2];
          end
          DONE: if (sck_rise && bit_cnt_q != '1) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign miso     = miso_q;
  assign address  = address_q;
  assign write_en = write_en_q;
  assign wr_data  = wr_data_q;
  assign read_en  = read_en_q;
`ifdef SPI_TARGET_STATUS_EN
  assign frame_err_cnt = err_cnt_q;
`endif

endmodule
